// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and parity helpers.
// Used by the buffered transmitter and intended for the future receiver.
package uart_pkg;

    // Widest character any UART block in this family handles.
    localparam int MAX_DATA_WIDTH = 9;

    // Bit counter width, large enough to index MAX_DATA_WIDTH data bits.
    localparam int BIT_CNT_WIDTH = 4;

    // Parity selection as it appears on the configuration register.
    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_e;

    // Serial frame phases of the transmitter.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Maps the raw 2-bit register value to a parity mode; the unused
    // encoding 3 behaves as no parity.
    function automatic parity_e decode_parity(input logic [1:0] mode);
        parity_e result;
        case (mode)
            2'd1:    result = PARITY_EVEN;
            2'd2:    result = PARITY_ODD;
            default: result = PARITY_NONE;
        endcase
        return result;
    endfunction

    // Parity bit for a character; unused upper bits must be zero.
    // EVEN sends the XOR of the data bits, ODD sends its inverse.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                        input parity_e                   mode);
        logic x;
        x = ^data;
        return (mode == PARITY_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous single-clock FIFO with first-word-fall-through read data.
// Occupancy is tracked in a count register; the full/empty flags are
// registered copies derived from the next count, never from pointer equality.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int LEVEL_WIDTH = PTR_WIDTH + 1;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   push_ok;
    logic                   pop_ok;

    // Qualify requests against the registered flags and compute the next
    // pointers, count and flags; a push while full is dropped even if a pop
    // happens in the same cycle.
    always_comb begin
        push_ok  = i_push && !full_q;
        pop_ok   = i_pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LEVEL_WIDTH'(1);
            2'b01:   count_d = count_q - LEVEL_WIDTH'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == LEVEL_WIDTH'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Pointer, count and flag registers, cleared by reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset because the count gates reads.
    always_ff @(posedge i_clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_level = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a FIFO of queued characters feeds a frame FSM
// with a built-in baud divider. Divisor, parity and stop-bit settings are
// captured when a character is popped, so register writes made while a
// frame is on the wire only affect later frames.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_we,
    input  logic [DIV_WIDTH-1:0]          i_divisor,
    input  logic [1:0]                    i_parity,
    input  logic                          i_stop2,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_busy,
    output logic                          o_tx
);

    logic                     fifo_pop;
    logic [DATA_WIDTH-1:0]    fifo_data;
    logic                     fifo_empty;

    tx_state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]     div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0]     divisor_q, divisor_d;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    parity_e                  parity_mode_q, parity_mode_d;
    logic                     parity_bit_q, parity_bit_d;
    logic                     stop2_q, stop2_d;
    logic                     tx_q, tx_d;
    logic                     bit_tick;
    logic                     last_data_bit;

    uart_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (i_we),
        .i_data  (i_data),
        .i_pop   (fifo_pop),
        .o_data  (fifo_data),
        .o_full  (o_full),
        .o_empty (fifo_empty),
        .o_level (o_level)
    );

    assign bit_tick      = (div_cnt_q == '0);
    assign last_data_bit = (bit_cnt_q == BIT_CNT_WIDTH'(DATA_WIDTH - 1));

    // Next-state logic: the divider counts down each bit period and reloads
    // at every bit boundary, where the FSM advances through the frame and the
    // serial line value for the next cycle is chosen.
    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        divisor_d     = divisor_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_mode_d = parity_mode_q;
        parity_bit_d  = parity_bit_q;
        stop2_d       = stop2_q;
        fifo_pop      = 1'b0;
        tx_d          = 1'b1;

        if (state_q != IDLE) begin
            div_cnt_d = bit_tick ? divisor_q : (div_cnt_q - DIV_WIDTH'(1));
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shift_d       = fifo_data;
                    divisor_d     = i_divisor;
                    div_cnt_d     = i_divisor;
                    parity_mode_d = decode_parity(i_parity);
                    parity_bit_d  = parity_bit(MAX_DATA_WIDTH'(fifo_data),
                                               decode_parity(i_parity));
                    stop2_d       = i_stop2;
                    bit_cnt_d     = '0;
                    state_d       = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (last_data_bit) begin
                        bit_cnt_d = '0;
                        state_d   = (parity_mode_q == PARITY_NONE) ? STOP : PARITY;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_WIDTH'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BIT_CNT_WIDTH'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State, divider, frame and line registers; reset aborts any frame and
    // parks the line high.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= IDLE;
            div_cnt_q     <= '0;
            divisor_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_mode_q <= PARITY_NONE;
            parity_bit_q  <= 1'b0;
            stop2_q       <= 1'b0;
            tx_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            divisor_q     <= divisor_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_mode_q <= parity_mode_d;
            parity_bit_q  <= parity_bit_d;
            stop2_q       <= stop2_d;
            tx_q          <= tx_d;
        end
    end

    assign o_empty = fifo_empty;
    assign o_busy  = (state_q != IDLE) || !fifo_empty;
    assign o_tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: queued characters are recorded
// in a scoreboard with their expected frame settings, and a line monitor
// rebuilds each expected frame and compares it clock by clock.
module tb_uart_tx_buffered;

    localparam int DATA_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV_WIDTH  = 16;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        int                    divisor;
        int                    parity;
        bit                    stop2;
    } frame_t;

    logic                         i_clock = 1'b0;
    logic                         i_reset;
    logic [DATA_WIDTH-1:0]        i_data;
    logic                         i_we;
    logic [DIV_WIDTH-1:0]         i_divisor;
    logic [1:0]                   i_parity;
    logic                         i_stop2;
    logic                         o_full;
    logic                         o_empty;
    logic [$clog2(FIFO_DEPTH):0]  o_level;
    logic                         o_busy;
    logic                         o_tx;

    frame_t sbQueue[$];
    int     checks     = 0;
    int     errors     = 0;
    int     cyc        = 0;
    int     framesSeen = 0;
    bit     checkGap   = 1'b0;
    bit     gapValid   = 1'b0;

    uart_tx_buffered #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_data    (i_data),
        .i_we      (i_we),
        .i_divisor (i_divisor),
        .i_parity  (i_parity),
        .i_stop2   (i_stop2),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_level   (o_level),
        .o_busy    (o_busy),
        .o_tx      (o_tx)
    );

    // Free-running clock and a cycle counter stepped on each rising edge.
    always #5 i_clock = ~i_clock;

    initial begin
        forever begin
            @(posedge i_clock);
            cyc++;
        end
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one write strobe across one rising edge; accepted characters
    // are recorded with the frame settings they should be sent with.
    task automatic applyStimulus(input logic [DATA_WIDTH-1:0] data, input bit accept,
                                 input int expDiv, input int expPar, input bit expStop2);
        frame_t f;
        if (accept) begin
            f.data    = data;
            f.divisor = expDiv;
            f.parity  = expPar;
            f.stop2   = expStop2;
            sbQueue.push_back(f);
        end
        i_data = data;
        i_we   = 1'b1;
        @(posedge i_clock);
        #1;
        i_we   = 1'b0;
    endtask

    // Waits, with a cycle budget, for o_busy to drop; returns the cycle count.
    task automatic waitIdle(input int budget, output int fallCyc);
        int n;
        n = 0;
        @(negedge i_clock);
        while (o_busy !== 1'b0 && n < budget) begin
            @(negedge i_clock);
            n++;
        end
        if (o_busy !== 1'b0) begin
            checkOutput("idle_timeout", {31'd0, o_busy}, 32'd0);
        end
        fallCyc = cyc;
    endtask

    // Line monitor: a low level on an idle line starts a frame, which is
    // checked against the next scoreboard entry on every clock of every bit.
    initial begin : monitor
        frame_t exp;
        bit     bits[$];
        bit     abortFrame;
        int     startCyc;
        int     prevEnd;
        int     frameIdx;
        frameIdx = 0;
        prevEnd  = 0;
        forever begin
            @(negedge i_clock);
            if (i_reset === 1'b0 && o_tx === 1'b0) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_frame", 32'd1, 32'd0);
                    for (int n = 0; n < 5000 && o_tx === 1'b0; n++) begin
                        @(negedge i_clock);
                    end
                end else begin
                    exp = sbQueue.pop_front();
                    bits.delete();
                    bits.push_back(1'b0);
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        bits.push_back(exp.data[i]);
                    end
                    if (exp.parity == 1) bits.push_back(^exp.data);
                    if (exp.parity == 2) bits.push_back(~^exp.data);
                    bits.push_back(1'b1);
                    if (exp.stop2) bits.push_back(1'b1);
                    startCyc = cyc;
                    if (checkGap && gapValid) begin
                        checkOutput($sformatf("gap_before_frame%0d", frameIdx),
                                    startCyc - prevEnd, 32'd2);
                    end
                    abortFrame = 1'b0;
                    for (int b = 0; b < bits.size() && !abortFrame; b++) begin
                        for (int k = 0; k <= exp.divisor && !abortFrame; k++) begin
                            if (b != 0 || k != 0) @(negedge i_clock);
                            if (i_reset !== 1'b0) begin
                                abortFrame = 1'b1;
                            end else begin
                                checkOutput($sformatf("frame%0d_bit%0d", frameIdx, b),
                                            {31'd0, o_tx}, {31'd0, bits[b]});
                            end
                        end
                    end
                    if (!abortFrame) begin
                        prevEnd  = cyc;
                        gapValid = 1'b1;
                        framesSeen++;
                    end else begin
                        gapValid = 1'b0;
                    end
                    frameIdx++;
                end
            end
        end
    end

    // Main sequence of directed scenarios.
    initial begin : stimulus
        int c0;
        int cEnd;
        int framesBefore;

        i_reset   = 1'b1;
        i_we      = 1'b0;
        i_data    = '0;
        i_divisor = 16'd3;
        i_parity  = 2'd0;
        i_stop2   = 1'b0;
        repeat (3) @(posedge i_clock);
        #1;
        i_reset = 1'b0;

        checkOutput("reset_tx",    {31'd0, o_tx},    32'd1);
        checkOutput("reset_busy",  {31'd0, o_busy},  32'd0);
        checkOutput("reset_empty", {31'd0, o_empty}, 32'd1);
        checkOutput("reset_full",  {31'd0, o_full},  32'd0);
        checkOutput("reset_level", {27'd0, o_level}, 32'd0);

        // 8N1, divisor 3: 40-clock frame, busy drops one cycle after STOP.
        $display("[TB] 8N1 single frame");
        i_divisor = 16'd3;
        applyStimulus(8'hA5, 1'b1, 3, 0, 1'b0);
        c0 = cyc;
        checkOutput("level_after_write", {27'd0, o_level}, 32'd1);
        checkOutput("empty_after_write", {31'd0, o_empty}, 32'd0);
        checkOutput("tx_before_pop",     {31'd0, o_tx},    32'd1);
        @(posedge i_clock);
        #1;
        checkOutput("tx_after_pop",    {31'd0, o_tx},    32'd0);
        checkOutput("level_after_pop", {27'd0, o_level}, 32'd0);
        waitIdle(1000, cEnd);
        checkOutput("8n1_busy_fall", cEnd - c0, 32'd41);
        checkOutput("8n1_pending", sbQueue.size(), 32'd0);

        // Even parity, divisor 0: 11-clock frame.
        $display("[TB] even parity");
        i_parity  = 2'd1;
        i_divisor = 16'd0;
        applyStimulus(8'h03, 1'b1, 0, 1, 1'b0);
        c0 = cyc;
        waitIdle(1000, cEnd);
        checkOutput("even_busy_fall", cEnd - c0, 32'd12);

        // Odd parity with two stop bits: 12-clock frame.
        $display("[TB] odd parity two stop bits");
        i_parity = 2'd2;
        i_stop2  = 1'b1;
        applyStimulus(8'h07, 1'b1, 0, 2, 1'b1);
        c0 = cyc;
        waitIdle(1000, cEnd);
        checkOutput("odd_busy_fall", cEnd - c0, 32'd13);
        i_parity = 2'd0;
        i_stop2  = 1'b0;

        // Overflow: 17 pushes fill the FIFO after one pop, the 18th drops.
        $display("[TB] FIFO overflow");
        i_divisor = 16'd100;
        gapValid  = 1'b0;
        checkGap  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'(8'h3C + i * 17), 1'b1, 100, 0, 1'b0);
        end
        checkOutput("ovf_full",  {31'd0, o_full},  32'd1);
        checkOutput("ovf_level", {27'd0, o_level}, 32'd16);
        applyStimulus(8'hFF, 1'b0, 100, 0, 1'b0);
        checkOutput("ovf_full_after_drop",  {31'd0, o_full},  32'd1);
        checkOutput("ovf_level_after_drop", {27'd0, o_level}, 32'd16);
        waitIdle(20000, cEnd);
        checkOutput("ovf_pending", sbQueue.size(), 32'd0);
        checkGap = 1'b0;

        // Divisor change mid-frame only affects the following frame.
        $display("[TB] config latching");
        i_divisor = 16'd3;
        applyStimulus(8'h5A, 1'b1, 3, 0, 1'b0);
        c0 = cyc;
        applyStimulus(8'hC3, 1'b1, 7, 0, 1'b0);
        repeat (6) @(posedge i_clock);
        #1;
        i_divisor = 16'd7;
        waitIdle(2000, cEnd);
        checkOutput("cfg_total_cycles", cEnd - c0, 32'd122);
        checkOutput("cfg_pending", sbQueue.size(), 32'd0);

        // Reset during DATA with three characters still queued.
        $display("[TB] reset mid-frame");
        i_divisor = 16'd3;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(8'h81 + i), 1'b1, 3, 0, 1'b0);
        end
        repeat (12) @(posedge i_clock);
        #1;
        checkOutput("pre_reset_level", {27'd0, o_level}, 32'd3);
        i_reset = 1'b1;
        sbQueue.delete();
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        checkOutput("post_reset_tx",    {31'd0, o_tx},    32'd1);
        checkOutput("post_reset_level", {27'd0, o_level}, 32'd0);
        checkOutput("post_reset_busy",  {31'd0, o_busy},  32'd0);
        checkOutput("post_reset_empty", {31'd0, o_empty}, 32'd1);
        checkOutput("post_reset_full",  {31'd0, o_full},  32'd0);
        framesBefore = framesSeen;
        repeat (200) @(posedge i_clock);
        #1;
        checkOutput("frames_after_reset", framesSeen - framesBefore, 32'd0);
        checkOutput("tx_idle_after_reset", {31'd0, o_tx}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised buffered UART transmitter. It replaces the fixed 8N1 transmitter with one that has:
- configurable data width, parity and stop bits;
- an internal baud-rate divider;
- a FIFO, so the CPU-side bus can queue several characters without polling between bytes.

It sits between the peripheral register interface and the TX pad.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
- DIV_WIDTH, 16, width of the baud divisor.

Ports:
- i_clock  in  1  clock; all logic on rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_data  in  DATA_WIDTH  character to queue.
- i_we  in  1  write strobe; pushes i_data when o_full=0.
- i_divisor  in  DIV_WIDTH  bit period minus one, in clocks.
- i_parity  in  2  parity mode: NONE=0, EVEN=1, ODD=2, value 3 treated as NONE.
- i_stop2  in  1  1 = two stop bits, 0 = one stop bit.
- o_full  out  1  FIFO full.
- o_empty  out  1  FIFO empty.
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_busy  out  1  frame in progress or FIFO not empty.
- o_tx  out  1  serial line; idle high.

## Operation
- **FIFO write:** when i_we=1 and o_full=0, i_data is pushed at the edge. A write while o_full=1 is silently dropped.
- **Full decision:** o_full is registered. A write in the same cycle as a pop while full is still dropped.
- **Frame start:** in IDLE with o_empty=0, the FSM pops the head entry and latches it. In the same edge it latches i_divisor, i_parity and i_stop2. Changes to these inputs mid-frame do not affect the current frame.
- **FSM states:**
  - IDLE: o_tx=1. Pop when not empty, then go to START.
  - START: o_tx=0 for one bit period, then DATA.
  - DATA: DATA_WIDTH bits, LSB first, one bit period each. Then PARITY if parity≠NONE, else STOP.
  - PARITY: EVEN drives the XOR of the data bits; ODD drives its inverse. One bit period, then STOP.
  - STOP: o_tx=1 for one bit period, or two when the latched stop2=1. Then IDLE.
- **Bit period:** exactly latched divisor+1 clocks. The divider counter reloads at every bit boundary; divisor=0 gives one clock per bit.
- **Back-to-back frames:** if the FIFO is non-empty at the end of STOP, the FSM passes through IDLE for exactly one clock (o_tx=1) and pops the next entry.
- **o_busy:** (state≠IDLE) or (o_empty=0).
- **Reset (any cycle, including mid-frame):**
  - FIFO cleared and the frame aborted; state returns to IDLE.
  - Outputs after the reset edge: o_tx=1, o_busy=0, o_empty=1, o_full=0, o_level=0.
  - Internal data and counter registers may reset to zero.

## Timing
- **Write into an empty FIFO while IDLE:**
  - write at edge N;
  - o_empty=0 and o_level=1 after N;
  - pop at edge N+1;
  - o_tx=0 from after N+1 (one-cycle latency).
- **Frame length:** (1 + DATA_WIDTH + P + S)·(div+1) clocks, where P ∈ {0,1} and S ∈ {1,2}.
- **Pop timing:** o_level decrements at the pop edge. A simultaneous push and pop leaves o_level unchanged.
- **FIFO pointers:** wrap modulo FIFO_DEPTH. Full/empty flags derive from a count register, not from pointer equality.

## Structure
- Package uart_pkg holds:
  - the parity enum (PARITY_NONE, PARITY_EVEN, PARITY_ODD);
  - the TX state enum (IDLE, START, DATA, PARITY, STOP).

  Future UART blocks (RX) share this package.
- Sub-module uart_fifo: synchronous single-clock FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/level. It is reused by the planned receiver.
- The divider, bit counter and FSM live in the top module.

## Test plan
- **8N1, single frame:** divisor=3, push 0xA5. o_tx low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks; total 40 clocks; o_busy falls the cycle after STOP ends.
- **Parity, even:** i_parity=EVEN, divisor=0, push 0x03. Parity bit = 0; frame is 11 clocks.
- **Parity, odd with two stop bits:** i_parity=ODD, i_stop2=1, push 0x07. Parity bit = 0; stop high for 2 bit periods; frame is 12 clocks.
- **FIFO overflow:** hold divisor=100, push 17 distinct bytes in consecutive cycles. The first pops immediately, so 16 stay queued and o_full=1 after the 17th edge; an 18th push is dropped. Drain the FIFO; the serialised sequence matches the first 17 bytes in order, with exactly one idle-high clock between frames.
- **Config latching:** change i_divisor from 3 to 7 mid-frame. The current frame keeps 4-clock bits; the next frame uses 8-clock bits.
- **Reset mid-frame:** assert i_reset during DATA with 3 bytes queued. After the reset edge: o_tx=1, o_level=0, o_busy=0, and no further frames are transmitted.
